pipe_stage_reg: RTL and testbench

Parametrised pipeline-stage register, the generalised successor to the fixed MEM/WB latch. It carries an arbitrary payload plus a control field between two pipeline stages using a valid/ready handshake. It also supports flush (bubble insertion) and an optional 2-entry skid buffer that registers the upstream ready path. It is instantiated at every stage boundary: IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/dff.sv | 19 +
 rtl/pipe_stage_reg_slot.sv | 36 +++
 rtl/pipe_stage_reg.sv | 122 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings and field layout for pipeline-stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } pipe_state_e;

  localparam int PIPE_DATA_W = 48;
  localparam int PIPE_CTRL_W = 8;

  // MEM/WB payload layout: {memdata, aluresult, instr}
  localparam int MW_INSTR_LSB   = 0;
  localparam int MW_INSTR_W     = 16;
  localparam int MW_ALU_LSB     = 16;
  localparam int MW_ALU_W       = 16;
  localparam int MW_MEMDATA_LSB = 32;
  localparam int MW_MEMDATA_W   = 16;

  // MEM/WB control layout; bit 7 is spare
  localparam int MW_REGTOWRITE_LSB = 0;
  localparam int MW_REGTOWRITE_W   = 4;
  localparam int MW_REGWRITE_BIT   = 4;
  localparam int MW_MEMTOREG_BIT   = 5;
  localparam int MW_INVAL_BIT      = 6;

endpackage

// File: rtl/dff.sv
// Generic enabled D flip-flop bank with synchronous active-low clear to zero.
module dff #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst)    r_q <= '0;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/pipe_stage_reg_slot.sv
// One pipeline slot: valid bit, control field and payload.
// Clear kills valid and control but leaves the payload untouched.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_clr,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);
  logic w_en;
  assign w_en = i_load | i_clr;

  dff #(.W(1)) u_valid (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(w_en),
    .i_d(~i_clr), .o_q(o_valid)
  );

  dff #(.W(CTRL_W)) u_ctrl (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(w_en),
    .i_d(i_clr ? '0 : i_ctrl), .o_q(o_ctrl)
  );

  dff #(.W(DATA_W)) u_data (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_load & ~i_clr),
    .i_d(i_data), .o_q(o_data)
  );
endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline-stage register with flush and optional 2-entry skid.
//   state    | meaning
//   ST_EMPTY | no entry held, in_ready=1
//   ST_ONE   | main slot valid, in_ready=1
//   ST_FULL  | main and skid valid, in_ready=0
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int SKID   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic [CTRL_W-1:0] i_in_ctrl,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic [CTRL_W-1:0] o_out_ctrl,
  input  logic              i_flush,
  output logic [1:0]        o_occ
);
  logic              w_in_xfer, w_out_xfer;
  logic              w_main_load, w_main_clr, w_main_valid;
  logic [CTRL_W-1:0] w_main_ctrl, w_main_ctrl_d;
  logic [DATA_W-1:0] w_main_data, w_main_data_d;

  assign w_in_xfer  = i_in_valid & o_in_ready;
  assign w_out_xfer = w_main_valid & i_out_ready;

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(w_main_load), .i_clr(w_main_clr),
    .i_ctrl(w_main_ctrl_d), .i_data(w_main_data_d),
    .o_valid(w_main_valid), .o_ctrl(w_main_ctrl), .o_data(w_main_data)
  );

  assign o_out_valid = w_main_valid;
  assign o_out_data  = w_main_data;
  assign o_out_ctrl  = w_main_valid ? w_main_ctrl : '0;

  if (SKID != 0) begin : g_skid
    pipe_state_e       r_state;
    logic              r_in_ready;
    logic              w_skid_load, w_skid_clr, w_skid_valid;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
      .i_clk(i_clk), .i_rst(i_rst), .i_load(w_skid_load), .i_clr(w_skid_clr),
      .i_ctrl(i_in_ctrl), .i_data(i_in_data),
      .o_valid(w_skid_valid), .o_ctrl(w_skid_ctrl), .o_data(w_skid_data)
    );

    always_ff @(posedge i_clk) begin
      if (!i_rst) begin
        r_state    <= ST_EMPTY;
        r_in_ready <= 1'b0;
      end else if (i_flush) begin
        r_state    <= ST_EMPTY;
        r_in_ready <= 1'b1;
      end else begin
        case (r_state)
          ST_EMPTY: begin
            if (w_in_xfer) r_state <= ST_ONE;
            r_in_ready <= 1'b1;
          end
          ST_ONE: begin
            if (w_in_xfer && !w_out_xfer) begin
              r_state    <= ST_FULL;
              r_in_ready <= 1'b0;
            end else begin
              if (!w_in_xfer && w_out_xfer) r_state <= ST_EMPTY;
              r_in_ready <= 1'b1;
            end
          end
          ST_FULL: begin
            if (w_out_xfer) begin
              r_state    <= ST_ONE;
              r_in_ready <= 1'b1;
            end
          end
          default: begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
          end
        endcase
      end
    end

    // In FULL the main slot refills from skid; otherwise straight from upstream
    assign w_main_load = ~i_flush &
                         (((r_state == ST_EMPTY) & w_in_xfer) |
                          ((r_state == ST_ONE)   & w_in_xfer & w_out_xfer) |
                          ((r_state == ST_FULL)  & w_out_xfer));
    assign w_main_clr  = i_flush | ((r_state == ST_ONE) & w_out_xfer & ~w_in_xfer);
    assign w_skid_load = ~i_flush & (r_state == ST_ONE) & w_in_xfer & ~w_out_xfer;
    assign w_skid_clr  = i_flush | ((r_state == ST_FULL) & w_out_xfer);

    assign w_main_data_d = (r_state == ST_FULL) ? w_skid_data : i_in_data;
    assign w_main_ctrl_d = (r_state == ST_FULL) ? w_skid_ctrl : i_in_ctrl;
    assign o_in_ready    = r_in_ready;
    assign o_occ         = 2'(w_main_valid) + 2'(w_skid_valid);
  end else begin : g_single
    logic r_run;

    // Holds in_ready low through reset even though the slot is empty
    always_ff @(posedge i_clk) begin
      if (!i_rst) r_run <= 1'b0;
      else        r_run <= 1'b1;
    end

    assign w_main_load   = ~i_flush & w_in_xfer;
    assign w_main_clr    = i_flush | (w_out_xfer & ~w_in_xfer);
    assign w_main_data_d = i_in_data;
    assign w_main_ctrl_d = i_in_ctrl;
    assign o_in_ready    = r_run & (~w_main_valid | i_out_ready);
    assign o_occ         = {1'b0, w_main_valid};
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: SKID=1 and SKID=0 stages driven by shared stimulus,
// each compared against a queue-style reference model.
module tb_pipe_stage_reg;
  localparam int DW = 48;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;

  logic          rdy1, ov1, rdy0, ov0;
  logic [DW-1:0] od1, od0;
  logic [CW-1:0] oc1, oc0;
  logic [1:0]    occ1, occ0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(rdy1),
    .i_in_data(in_data), .i_in_ctrl(in_ctrl), .o_out_valid(ov1),
    .i_out_ready(out_ready), .o_out_data(od1), .o_out_ctrl(oc1),
    .i_flush(flush), .o_occ(occ1)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(rdy0),
    .i_in_data(in_data), .i_in_ctrl(in_ctrl), .o_out_valid(ov0),
    .i_out_ready(out_ready), .o_out_data(od0), .o_out_ctrl(oc0),
    .i_flush(flush), .o_occ(occ0)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: per stage a FIFO of {ctrl,data} with capacity 2 (skid) or 1.
  logic [DW+CW-1:0] ent [2][2];
  int  cnt [2];
  bit  run [2];
  bit  acc [2];
  bit  was_rst  = 1'b0;
  bit  checking = 1'b0;

  function automatic bit mdl_ready(input int k);
    if (!run[k]) return 1'b0;
    if (k == 1)  return cnt[1] < 2;
    return (cnt[0] == 0) || out_ready;
  endfunction

  task automatic check_outputs();
    logic          ov, rdy;
    logic [DW-1:0] od;
    logic [CW-1:0] oc;
    logic [1:0]    occ;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin ov = ov1; rdy = rdy1; od = od1; oc = oc1; occ = occ1; end
      else        begin ov = ov0; rdy = rdy0; od = od0; oc = oc0; occ = occ0; end
      check_eq($sformatf("occ[skid=%0d]", k), 64'(occ), 64'(cnt[k]));
      check_eq($sformatf("out_valid[skid=%0d]", k), 64'(ov), 64'(cnt[k] > 0));
      check_eq($sformatf("in_ready[skid=%0d]", k), 64'(rdy), 64'(mdl_ready(k)));
      if (cnt[k] > 0) begin
        check_eq($sformatf("out_data[skid=%0d]", k), 64'(od), 64'(ent[k][0][DW-1:0]));
        check_eq($sformatf("out_ctrl[skid=%0d]", k), 64'(oc), 64'(ent[k][0][DW+CW-1:DW]));
      end else begin
        check_eq($sformatf("bubble_ctrl[skid=%0d]", k), 64'(oc), 64'd0);
      end
      if (was_rst)
        check_eq($sformatf("reset_data[skid=%0d]", k), 64'(od), 64'd0);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      acc[k] = 1'b0;
      if (!rst) begin
        cnt[k] = 0;
        run[k] = 1'b0;
      end else begin
        acc[k] = in_valid && mdl_ready(k);
        if (cnt[k] > 0 && out_ready) begin
          ent[k][0] = ent[k][1];
          cnt[k]--;
        end
        if (flush) cnt[k] = 0;
        else if (acc[k]) begin
          ent[k][cnt[k]] = {in_ctrl, in_data};
          cnt[k]++;
        end
        run[k] = 1'b1;
      end
    end
    was_rst = !rst;
  endtask

  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit ordy,
                       input bit fl, input bit r);
    @(negedge clk);
    if (checking) check_outputs();
    in_valid  = v;
    in_data   = d;
    in_ctrl   = CW'($urandom);
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    #1;
    if (checking) begin
      check_eq("in_ready_comb[skid=0]", 64'(rdy0), 64'(mdl_ready(0)));
      check_eq("in_ready_comb[skid=1]", 64'(rdy1), 64'(mdl_ready(1)));
    end
    @(posedge clk);
    model_step();
  endtask

  initial begin
    int idx;
    logic [63:0] rnd;

    // reset held for two edges with an entry offered upstream
    cycle(1'b1, 48'h1234, 1'b0, 1'b0, 1'b0);
    checking = 1'b1;
    cycle(1'b1, 48'h1234, 1'b0, 1'b0, 1'b0);

    // back-to-back streaming
    for (int i = 1; i <= 8; i++) cycle(1'b1, DW'(i), 1'b1, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // backpressure: 10,11,12 with out_ready dropped for a few cycles
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      cycle(idx < 3, DW'(10 + idx), !(c >= 1 && c < 5), 1'b0, 1'b1);
      if (acc[1]) idx++;
    end

    // flush while full, with 0x55 offered in the flush cycle
    cycle(1'b1, 48'h20, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 48'h21, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 48'h55, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // simultaneous in/out while holding one entry
    cycle(1'b1, 48'hA, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 48'hB, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // randomized traffic with occasional flush and reset
    for (int c = 0; c < 1500; c++) begin
      rnd = {$urandom, $urandom};
      cycle($urandom_range(0, 3) != 0, rnd[DW-1:0],
            $urandom_range(0, 9) < ((c / 100) % 2 == 0 ? 8 : 3),
            $urandom_range(0, 24) == 0, $urandom_range(0, 59) != 0);
    end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
